// File: rtl/e203_irq_stim_pkg.sv
// Shared types and constants for the E203 interrupt stimulus generator.
package e203_irq_stim_pkg;

    localparam int N_CHAN = 3;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_WAIT,
        CH_ASSERT,
        CH_DONE
    } chan_state_e;

    // x^16+x^14+x^13+x^11+1 in right-shift Fibonacci form: feedback from bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS         = 16'h002D;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] state);
        return {^(state & LFSR_TAPS), state[15:1]};
    endfunction

    // An all-zero state would lock the LFSR, so a zero seed falls back to the default.
    function automatic logic [15:0] lfsr_seed_fix(input logic [15:0] seed);
        return (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
    endfunction

endpackage

// File: rtl/e203_irq_stim_chan.sv
// One interrupt channel: free-running LFSR, gap counter and the
// IDLE/WAIT/ASSERT/DONE handshake FSM keyed to one handler commit PC.
module e203_irq_stim_chan
    import e203_irq_stim_pkg::*;
#(
    parameter int                 PC_SIZE    = 32,
    parameter logic [PC_SIZE-1:0] PC_HANDLER = '0,
    parameter int                 GAP_W      = 10,
    parameter logic [15:0]        SEED       = LFSR_DEFAULT_SEED
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               armed,
    input  logic               stopped,
    input  logic               cmt_valid,
    input  logic [PC_SIZE-1:0] cmt_pc,
    input  logic               cfg_fixed_en,
    input  logic [GAP_W-1:0]   cfg_fixed_gap,
    output logic               irq
);

    localparam logic [15:0]    SEED_EFF = lfsr_seed_fix(SEED);
    localparam logic [GAP_W:0] CNT_ONE  = {{GAP_W{1'b0}}, 1'b1};

    chan_state_e      state_reg;
    logic [GAP_W:0]   cnt_reg;
    logic             irq_reg;
    logic [15:0]      lfsr_reg;

    logic [GAP_W-1:0] gap_sel;
    logic [GAP_W:0]   gap_value;
    logic             handler_hit;

    always_comb begin
        gap_sel     = cfg_fixed_en ? cfg_fixed_gap : lfsr_reg[GAP_W-1:0];
        gap_value   = {1'b0, gap_sel} + CNT_ONE;
        handler_hit = cmt_valid && (cmt_pc == PC_HANDLER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= CH_IDLE;
            cnt_reg   <= '0;
            irq_reg   <= 1'b0;
            lfsr_reg  <= SEED_EFF;
        end else begin
            lfsr_reg <= lfsr_step(lfsr_reg);
            if (!en && (state_reg != CH_DONE)) begin
                state_reg <= CH_IDLE;
                irq_reg   <= 1'b0;
            end else begin
                case (state_reg)
                    CH_IDLE: begin
                        irq_reg <= 1'b0;
                        if (armed && !stopped) begin
                            cnt_reg   <= gap_value;
                            state_reg <= CH_WAIT;
                        end
                    end
                    CH_WAIT: begin
                        if (cnt_reg <= CNT_ONE) begin
                            state_reg <= CH_ASSERT;
                            irq_reg   <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg - CNT_ONE;
                        end
                    end
                    CH_ASSERT: begin
                        // stopped is registered, so a same-cycle tohost commit is not yet counted
                        if (handler_hit) begin
                            irq_reg <= 1'b0;
                            if (stopped) begin
                                state_reg <= CH_DONE;
                            end else begin
                                cnt_reg   <= gap_value;
                                state_reg <= CH_WAIT;
                            end
                        end
                    end
                    CH_DONE: begin
                        irq_reg <= 1'b0;
                    end
                    default: begin
                        state_reg <= CH_IDLE;
                        irq_reg   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign irq = irq_reg;

endmodule

// File: rtl/e203_irq_stim_gen.sv
// Interrupt stimulus generator: arms on a commit PC, counts tohost commits
// and drives ext/sft/tmr irq lines through three handshaking channels.
module e203_irq_stim_gen
    import e203_irq_stim_pkg::*;
#(
    parameter int                 PC_SIZE     = 32,
    parameter logic [PC_SIZE-1:0] PC_ARM      = 32'h8000015C,
    parameter logic [PC_SIZE-1:0] PC_TOHOST   = 32'h80000086,
    parameter logic [PC_SIZE-1:0] PC_EXT_MRET = 32'h800000A6,
    parameter logic [PC_SIZE-1:0] PC_SFT_MRET = 32'h800000BE,
    parameter logic [PC_SIZE-1:0] PC_TMR_MRET = 32'h800000D6,
    parameter int unsigned        STOP_CNT    = 32,
    parameter int                 GAP_W       = 10,
    parameter logic [15:0]        SEED_EXT    = 16'hACE1,
    parameter logic [15:0]        SEED_SFT    = 16'h1D2B,
    parameter logic [15:0]        SEED_TMR    = 16'h5A17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cmt_valid,
    input  logic [PC_SIZE-1:0] cmt_pc,
    input  logic               cfg_fixed_en,
    input  logic [GAP_W-1:0]   cfg_fixed_gap,
    output logic               ext_irq_o,
    output logic               sft_irq_o,
    output logic               tmr_irq_o,
    output logic               armed,
    output logic [31:0]        tohost_cnt,
    output logic               stopped,
    output logic               all_idle
);

    localparam logic [PC_SIZE-1:0] HANDLER_PC [N_CHAN] = '{PC_EXT_MRET, PC_SFT_MRET, PC_TMR_MRET};
    localparam logic [15:0]        CHAN_SEED  [N_CHAN] = '{SEED_EXT, SEED_SFT, SEED_TMR};

    logic              armed_reg;
    logic [31:0]       tohost_cnt_reg;
    logic              stopped_w;
    logic [N_CHAN-1:0] irq_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_reg      <= 1'b0;
            tohost_cnt_reg <= '0;
        end else begin
            if (cmt_valid && (cmt_pc == PC_ARM)) begin
                armed_reg <= 1'b1;
            end
            if (cmt_valid && (cmt_pc == PC_TOHOST) && (tohost_cnt_reg != 32'hFFFF_FFFF)) begin
                tohost_cnt_reg <= tohost_cnt_reg + 32'd1;
            end
        end
    end

    assign stopped_w = (tohost_cnt_reg > 32'(STOP_CNT));

    genvar gi;
    generate
        for (gi = 0; gi < N_CHAN; gi++) begin : g_chan
            e203_irq_stim_chan #(
                .PC_SIZE    (PC_SIZE),
                .PC_HANDLER (HANDLER_PC[gi]),
                .GAP_W      (GAP_W),
                .SEED       (CHAN_SEED[gi])
            ) u_chan (
                .clk           (clk),
                .rst           (rst),
                .en            (en),
                .armed         (armed_reg),
                .stopped       (stopped_w),
                .cmt_valid     (cmt_valid),
                .cmt_pc        (cmt_pc),
                .cfg_fixed_en  (cfg_fixed_en),
                .cfg_fixed_gap (cfg_fixed_gap),
                .irq           (irq_vec[gi])
            );
        end
    endgenerate

    assign ext_irq_o  = irq_vec[0];
    assign sft_irq_o  = irq_vec[1];
    assign tmr_irq_o  = irq_vec[2];
    assign armed      = armed_reg;
    assign tohost_cnt = tohost_cnt_reg;
    assign stopped    = stopped_w;
    assign all_idle   = ~|irq_vec;

endmodule

// File: tb/tb_e203_irq_stim_gen.sv
// Bench for e203_irq_stim_gen: directed handshake scenarios plus a randomised
// handler model checking gap bounds and per-channel independence.
module tb_e203_irq_stim_gen;

    localparam int          PC_SIZE  = 32;
    localparam int          GAP_W    = 10;
    localparam logic [31:0] PC_ARM   = 32'h8000015C;
    localparam logic [31:0] PC_TOHOST = 32'h80000086;
    localparam logic [31:0] PC_EXT   = 32'h800000A6;
    localparam logic [31:0] PC_SFT   = 32'h800000BE;
    localparam logic [31:0] PC_TMR   = 32'h800000D6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              cmt_valid = 1'b0;
    logic [31:0]       cmt_pc = '0;
    logic              cfg_fixed_en = 1'b1;
    logic [GAP_W-1:0]  cfg_fixed_gap = '0;
    logic              ext_irq_o, sft_irq_o, tmr_irq_o;
    logic              armed, stopped, all_idle;
    logic [31:0]       tohost_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    e203_irq_stim_gen #(
        .PC_SIZE     (PC_SIZE),
        .PC_ARM      (PC_ARM),
        .PC_TOHOST   (PC_TOHOST),
        .PC_EXT_MRET (PC_EXT),
        .PC_SFT_MRET (PC_SFT),
        .PC_TMR_MRET (PC_TMR),
        .STOP_CNT    (2),
        .GAP_W       (GAP_W),
        .SEED_EXT    (16'hACE1),
        .SEED_SFT    (16'h1D2B),
        .SEED_TMR    (16'h5A17)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .cmt_valid     (cmt_valid),
        .cmt_pc        (cmt_pc),
        .cfg_fixed_en  (cfg_fixed_en),
        .cfg_fixed_gap (cfg_fixed_gap),
        .ext_irq_o     (ext_irq_o),
        .sft_irq_o     (sft_irq_o),
        .tmr_irq_o     (tmr_irq_o),
        .armed         (armed),
        .tohost_cnt    (tohost_cnt),
        .stopped       (stopped),
        .all_idle      (all_idle)
    );

    // bit0 = ext, bit1 = sft, bit2 = tmr
    function automatic logic [2:0] irqs();
        return {tmr_irq_o, sft_irq_o, ext_irq_o};
    endfunction

    function automatic logic [31:0] handler_pc(input int c);
        case (c)
            0:       return PC_EXT;
            1:       return PC_SFT;
            default: return PC_TMR;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [31:0] pc);
        cmt_valid = 1'b1;
        cmt_pc    = pc;
        tick();
        cmt_valid = 1'b0;
        cmt_pc    = '0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        en = 1'b0;
        cmt_valid = 1'b0;
        cmt_pc = '0;
        cfg_fixed_en = 1'b1;
        cfg_fixed_gap = 10'd4;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Arms with fixed gap 4 and waits through the known 1+5 cycle latency.
    task automatic arm_fixed();
        en = 1'b1;
        cfg_fixed_en = 1'b1;
        cfg_fixed_gap = 10'd4;
        commit(PC_ARM);
        repeat (6) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++; if (irqs() !== 3'b000) begin bad++; $display("FAIL reset_irq: got %b want 000", irqs()); end
        total++; if (armed !== 1'b0) begin bad++; $display("FAIL reset_armed: got %b want 0", armed); end
        total++; if (tohost_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", tohost_cnt); end
        total++; if (stopped !== 1'b0) begin bad++; $display("FAIL reset_stopped: got %b want 0", stopped); end
        total++; if (all_idle !== 1'b1) begin bad++; $display("FAIL reset_all_idle: got %b want 1", all_idle); end
        tick();
        rst = 1'b0;
        en = 1'b1;
        cfg_fixed_en = 1'b1;
        cfg_fixed_gap = 10'd0;
        commit(PC_EXT);
        commit(PC_TOHOST);
        for (int k = 0; k < 40; k++) begin
            tick();
            total++; if (irqs() !== 3'b000) begin bad++; $display("FAIL unarmed_irq: cycle %0d got %b want 000", k, irqs()); end
        end
        total++; if (tohost_cnt !== 32'd1) begin bad++; $display("FAIL unarmed_cnt: got %0d want 1", tohost_cnt); end
        $display("test_reset: checks=%0d", total);
    endtask

    task automatic test_fixed_gap();
        pulse_reset();
        en = 1'b1;
        cfg_fixed_en = 1'b1;
        cfg_fixed_gap = 10'd4;
        repeat (3) tick();
        commit(PC_ARM);
        total++; if (armed !== 1'b1) begin bad++; $display("FAIL arm_armed: got %b want 1", armed); end
        total++; if (irqs() !== 3'b000) begin bad++; $display("FAIL arm_irq0: got %b want 000", irqs()); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            total++;
            if (irqs() !== ((k == 6) ? 3'b111 : 3'b000)) begin
                bad++; $display("FAIL fixed_rise: k=%0d got %b want %b", k, irqs(), (k == 6) ? 3'b111 : 3'b000);
            end
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            total++; if (irqs() !== 3'b111) begin bad++; $display("FAIL fixed_hold: k=%0d got %b want 111", k, irqs()); end
        end
        total++; if (all_idle !== 1'b0) begin bad++; $display("FAIL fixed_all_idle: got %b want 0", all_idle); end
        $display("test_fixed_gap: checks=%0d", total);
    endtask

    task automatic test_handshake();
        commit(PC_EXT);
        total++; if (irqs() !== 3'b110) begin bad++; $display("FAIL hs_ext_drop: got %b want 110", irqs()); end
        for (int k = 1; k <= 5; k++) begin
            tick();
            total++;
            if (irqs() !== ((k == 5) ? 3'b111 : 3'b110)) begin
                bad++; $display("FAIL hs_ext_rise: k=%0d got %b want %b", k, irqs(), (k == 5) ? 3'b111 : 3'b110);
            end
        end
        // minimum gap: low for exactly one sample
        cfg_fixed_gap = 10'd0;
        commit(PC_SFT);
        total++; if (irqs() !== 3'b101) begin bad++; $display("FAIL hs_sft_drop: got %b want 101", irqs()); end
        tick();
        total++; if (irqs() !== 3'b111) begin bad++; $display("FAIL hs_sft_min_gap: got %b want 111", irqs()); end
        cfg_fixed_gap = 10'd4;
        $display("test_handshake: checks=%0d", total);
    endtask

    task automatic test_corner();
        cmt_valid = 1'b0;
        cmt_pc = PC_TMR;
        repeat (3) tick();
        cmt_pc = '0;
        total++; if (irqs() !== 3'b111) begin bad++; $display("FAIL cc_invalid_pc: got %b want 111", irqs()); end
        commit(PC_TMR);
        total++; if (irqs() !== 3'b011) begin bad++; $display("FAIL cc_tmr_drop: got %b want 011", irqs()); end
        for (int k = 1; k <= 5; k++) begin
            if (k == 2) begin
                cmt_valid = 1'b1;
                cmt_pc = PC_TMR;
            end
            tick();
            cmt_valid = 1'b0;
            cmt_pc = '0;
            total++;
            if (irqs() !== ((k == 5) ? 3'b111 : 3'b011)) begin
                bad++; $display("FAIL cc_wait_hit: k=%0d got %b want %b", k, irqs(), (k == 5) ? 3'b111 : 3'b011);
            end
        end
        en = 1'b0;
        tick();
        total++; if (irqs() !== 3'b000) begin bad++; $display("FAIL cc_en_drop: got %b want 000", irqs()); end
        total++; if (all_idle !== 1'b1) begin bad++; $display("FAIL cc_en_all_idle: got %b want 1", all_idle); end
        repeat (8) tick();
        total++; if (irqs() !== 3'b000) begin bad++; $display("FAIL cc_en_low_hold: got %b want 000", irqs()); end
        en = 1'b1;
        tick();
        for (int k = 1; k <= 5; k++) begin
            tick();
            total++;
            if (irqs() !== ((k == 5) ? 3'b111 : 3'b000)) begin
                bad++; $display("FAIL cc_en_return: k=%0d got %b want %b", k, irqs(), (k == 5) ? 3'b111 : 3'b000);
            end
        end
        $display("test_corner: checks=%0d", total);
    endtask

    task automatic test_stop();
        for (int n = 1; n <= 3; n++) begin
            commit(PC_TOHOST);
            total++; if (tohost_cnt !== 32'(n)) begin bad++; $display("FAIL stop_cnt: n=%0d got %0d want %0d", n, tohost_cnt, n); end
            total++; if (stopped !== (n > 2)) begin bad++; $display("FAIL stop_flag: n=%0d got %b want %b", n, stopped, n > 2); end
        end
        total++; if (irqs() !== 3'b111) begin bad++; $display("FAIL stop_pre_hs: got %b want 111", irqs()); end
        commit(PC_EXT);
        total++; if (irqs() !== 3'b110) begin bad++; $display("FAIL stop_ext: got %b want 110", irqs()); end
        commit(PC_SFT);
        total++; if (irqs() !== 3'b100) begin bad++; $display("FAIL stop_sft: got %b want 100", irqs()); end
        commit(PC_TMR);
        total++; if (irqs() !== 3'b000) begin bad++; $display("FAIL stop_tmr: got %b want 000", irqs()); end
        total++; if (all_idle !== 1'b1) begin bad++; $display("FAIL stop_all_idle: got %b want 1", all_idle); end
        en = 1'b0;
        tick();
        en = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            total++; if (irqs() !== 3'b000) begin bad++; $display("FAIL stop_done_hold: k=%0d got %b want 000", k, irqs()); end
        end
        commit(PC_TOHOST);
        total++; if (tohost_cnt !== 32'd4) begin bad++; $display("FAIL stop_4th_cnt: got %0d want 4", tohost_cnt); end
        $display("test_stop: checks=%0d", total);
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        arm_fixed();
        commit(PC_TOHOST);
        total++; if (irqs() !== 3'b111) begin bad++; $display("FAIL mid_pre: got %b want 111", irqs()); end
        rst = 1'b1;
        #1;
        total++; if (irqs() !== 3'b000) begin bad++; $display("FAIL mid_irq: got %b want 000", irqs()); end
        total++; if (armed !== 1'b0) begin bad++; $display("FAIL mid_armed: got %b want 0", armed); end
        total++; if (tohost_cnt !== 32'd0) begin bad++; $display("FAIL mid_cnt: got %0d want 0", tohost_cnt); end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            total++; if (irqs() !== 3'b000) begin bad++; $display("FAIL mid_after: k=%0d got %b want 000", k, irqs()); end
        end
        $display("test_reset_mid: checks=%0d", total);
    endtask

    task automatic test_random();
        logic [2:0] prev;
        logic [2:0] cur;
        int low_cnt [3];
        bit measuring [3];
        int delay [3];
        int gap_log [3][64];
        int gap_n [3];
        int hit_ch;
        int r;
        int c2;
        bit same;

        pulse_reset();
        en = 1'b1;
        cfg_fixed_en = 1'b0;
        commit(PC_ARM);
        prev = irqs();
        for (int c = 0; c < 3; c++) begin
            low_cnt[c] = 0; measuring[c] = 1'b0; delay[c] = 0; gap_n[c] = 0;
        end

        for (int cyc = 0; cyc < 10000; cyc++) begin
            hit_ch = -1;
            cmt_valid = 1'b0;
            cmt_pc = 32'h80001000 + 32'($urandom_range(0, 255)) * 32'd4;
            for (int c = 0; c < 3; c++) begin
                if (prev[c] && delay[c] == 0 && hit_ch < 0) hit_ch = c;
            end
            if (hit_ch >= 0) begin
                cmt_valid = 1'b1;
                cmt_pc = handler_pc(hit_ch);
            end else begin
                r = $urandom_range(0, 7);
                c2 = $urandom_range(0, 2);
                if (r == 0 && !prev[c2]) begin
                    cmt_valid = 1'b1;
                    cmt_pc = handler_pc(c2);
                end else if (r == 1) begin
                    cmt_pc = handler_pc(c2);
                end else if (r < 4) begin
                    cmt_valid = 1'b1;
                end
            end
            tick();
            cmt_valid = 1'b0;
            cur = irqs();
            for (int c = 0; c < 3; c++) begin
                if (hit_ch == c) begin
                    total++;
                    if (cur[c] !== 1'b0) begin bad++; $display("FAIL rnd_hs_drop: ch=%0d cyc=%0d got %b want 0", c, cyc, cur[c]); end
                    measuring[c] = 1'b1;
                    low_cnt[c] = 0;
                end else if (prev[c]) begin
                    total++;
                    if (cur[c] !== 1'b1) begin bad++; $display("FAIL rnd_hold: ch=%0d cyc=%0d got %b want 1", c, cyc, cur[c]); end
                end
                if (cur[c] === 1'b0) begin
                    low_cnt[c]++;
                    if (measuring[c] && low_cnt[c] == 1025) begin
                        total++; bad++;
                        $display("FAIL rnd_gap_long: ch=%0d cyc=%0d got >1024 want 1..1024", c, cyc);
                    end
                end else if (!prev[c]) begin
                    if (measuring[c]) begin
                        total++;
                        if (low_cnt[c] < 1 || low_cnt[c] > 1024) begin
                            bad++; $display("FAIL rnd_gap_range: ch=%0d got %0d want 1..1024", c, low_cnt[c]);
                        end
                        if (gap_n[c] < 64) gap_log[c][gap_n[c]] = low_cnt[c];
                        gap_n[c]++;
                    end
                    delay[c] = $urandom_range(0, 12);
                end else if (hit_ch != c && delay[c] > 0) begin
                    delay[c]--;
                end
            end
            prev = cur;
        end

        for (int c = 0; c < 3; c++) begin
            total++;
            if (gap_n[c] < 3) begin bad++; $display("FAIL rnd_activity: ch=%0d got %0d gaps want >=3", c, gap_n[c]); end
        end
        for (int a = 0; a < 3; a++) begin
            for (int b = a + 1; b < 3; b++) begin
                same = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    if (gap_n[a] <= i || gap_n[b] <= i || gap_log[a][i] != gap_log[b][i]) same = 1'b0;
                end
                total++;
                if (same) begin bad++; $display("FAIL rnd_distinct: ch%0d and ch%0d got identical gaps want distinct", a, b); end
            end
        end
        $display("test_random: gaps ext=%0d sft=%0d tmr=%0d checks=%0d", gap_n[0], gap_n[1], gap_n[2], total);
    endtask

    initial begin
        test_reset();
        test_fixed_gap();
        test_handshake();
        test_corner();
        test_stop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/e203_irq_stim_gen.md
# e203_irq_stim_gen

- Synthesizable interrupt stimulus generator that drives the external, software and timer interrupt lines of the E203 subsystem (`plic_ext_irq`, `clint_sft_irq`, `clint_tmr_irq` nets).
- It watches the EXU commit stream (valid plus PC) to decide when to arm, when each handler has reached its `mret`, and when to stop.
- It replaces bench-side `force` stimulus, so irq stress runs on FPGA and in gate-level simulation.
- It sits between the commit stage output and the subsystem irq inputs.

## Interface
Parameters:
- `PC_SIZE`, 32, PC width.
- `PC_ARM`, 32'h8000015C, commit PC that arms the generator (after mtvec is set).
- `PC_TOHOST`, 32'h80000086, commit PC counted as a tohost write.
- `PC_EXT_MRET`, 32'h800000A6, ext handler PC just before `mret`.
- `PC_SFT_MRET`, 32'h800000BE, sft handler PC just before `mret`.
- `PC_TMR_MRET`, 32'h800000D6, tmr handler PC just before `mret`.
- `STOP_CNT`, 32, stop once tohost count > STOP_CNT.
- `GAP_W`, 10, random gap width; gap range is 1..2^GAP_W cycles.
- `SEED_EXT` / `SEED_SFT` / `SEED_TMR`, 16'hACE1 / 16'h1D2B / 16'h5A17, per-channel LFSR seeds.

Ports:
- `clk`  in  1  core clock (hfclk domain).
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  global enable. Low: channels go to IDLE and all irqs drop.
- `cmt_valid`  in  1  ALU commit valid.
- `cmt_pc`  in  PC_SIZE  ALU commit PC.
- `cfg_fixed_en`  in  1  use `cfg_fixed_gap` instead of the LFSR.
- `cfg_fixed_gap`  in  GAP_W  deterministic gap value.
- `ext_irq_o` / `sft_irq_o` / `tmr_irq_o`  out  1 each  registered irq outputs.
- `armed`  out  1  sticky, set by a PC_ARM commit.
- `tohost_cnt`  out  32  count of tohost commits, saturating.
- `stopped`  out  1  `tohost_cnt > STOP_CNT`.
- `all_idle`  out  1  no irq currently asserted.

## Operation
Commit hit definition:
- A "hit on X" is `cmt_valid & (cmt_pc == X)` sampled at a `clk` edge.
- With `cmt_valid` low, PC values are ignored.

Shared logic:
- `armed` is set on a PC_ARM hit and cleared only by `rst`.
- `tohost_cnt` increments by 1 on each PC_TOHOST hit and saturates at 32'hFFFFFFFF.
- `stopped` is combinational from `tohost_cnt`.

Three identical channels; each maps to one handler PC.

LFSR:
- 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
- Free-running every cycle out of reset.
- A seed of 0 is replaced by 16'hACE1.

Gap value: `g = (cfg_fixed_en ? cfg_fixed_gap : lfsr[GAP_W-1:0]) + 1`, held in a GAP_W+1-bit counter.

Channel FSM:
- IDLE: irq=0. If `en & armed & !stopped`, load counter with g and go to WAIT.
- WAIT: irq=0. Counter decrements each cycle. When counter==1, go to ASSERT.
- ASSERT: irq=1. On a handler-PC hit, go to DONE if `stopped`, else reload g and go to WAIT.
- DONE: irq=0, terminal until `rst`.

FSM rules:
- `en` low in any state other than DONE forces IDLE next cycle.
- A handler-PC hit outside ASSERT is ignored.
- A PC_TOHOST hit and a handler hit in the same cycle: `stopped` is evaluated on the pre-increment count.

## Timing
Reset values (async on `rst`):
- FSM=IDLE, all irq outputs 0, `armed`=0, `tohost_cnt`=0.
- LFSR reloads its seed; `stopped`=0; `all_idle`=1.

Latencies:
- PC_ARM hit at edge t: `armed`=1 after t. Channel enters WAIT after t+1 with counter g. irq rises after edge t+1+g.
- Handler hit at edge t: irq low after t. Next assertion g cycles later (g ≥ 1), so minimum low time is 1 cycle.
- `en` falling, sampled at edge t: irq low after t.
- `rst` mid-assert: irq drops asynchronously.
- Outputs are registered, with no combinational path from `cmt_*` to `*_irq_o`.

## Structure
- Package `e203_irq_stim_pkg`: channel state enum (IDLE/WAIT/ASSERT/DONE), LFSR tap constant, the 16'hACE1 default seed.
- Sub-module `e203_irq_stim_chan`: FSM plus LFSR plus gap counter, parameterised by handler PC and seed. It is instantiated three times.
- The top holds only `armed`, `tohost_cnt`, `stopped` and `all_idle`.

## Test plan
- Reset: assert `rst` mid-run → all irqs 0, `tohost_cnt`=0, `armed`=0 immediately. After release, no irq until a PC_ARM hit.
- Fixed gap: `cfg_fixed_en`=1, `cfg_fixed_gap`=4, PC_ARM hit at edge 10 → each irq rises after edge 16 and stays high until its handler-PC hit.
- Handshake: handler-PC hit for ext at edge 50 → `ext_irq_o` low after 50 and high again after edge 55. `sft_irq_o` and `tmr_irq_o` are unaffected.
- Stop: STOP_CNT=2, drive 3 PC_TOHOST hits, then handler hits → all channels reach DONE, `all_idle`=1, no further irqs. A 4th tohost hit still counts.
- Corner cases: handler PC with `cmt_valid`=0 → ignored. Handler hit during WAIT → ignored. `en` drop during ASSERT → irq low next cycle, FSM re-enters IDLE then WAIT when `en` returns.
- Random: `cfg_fixed_en`=0, 10k cycles with a bench handler model → each gap lies in 1..1024 and the three channels follow distinct sequences.
